// File: rtl/nav_pkg.sv
// nav_pkg: heading/turn codes, FSM states and the arena adjacency table for path_navigator.
// Arena is an 8x4 grid, id = row*8 + col; N = +8, E = -1, S = -8, W = +1 without row wrap.
package nav_pkg;
    localparam int NODE_W_DEF = 5;
    localparam int ARENA_COLS = 8;
    localparam int ARENA_NODES = 32;

    typedef enum logic [1:0] {HEAD_N, HEAD_E, HEAD_S, HEAD_W} heading_e;
    typedef enum logic [1:0] {TURN_STRAIGHT, TURN_RIGHT, TURN_UTURN, TURN_LEFT} turn_e;
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_PRESENT, S_DONE, S_ERR} state_e;

    // Each entry is {valid, neighbour id}, indexed by node then absolute heading.
    typedef logic [3:0][NODE_W_DEF:0] adj_row_t;
    typedef adj_row_t [ARENA_NODES-1:0] adj_t;

    function automatic adj_t build_adj();
        adj_t t = '0;
        int c;
        for (int n = 0; n < ARENA_NODES; n++) begin
            c = n % ARENA_COLS;
            if (n + ARENA_COLS < ARENA_NODES) t[n[NODE_W_DEF-1:0]][HEAD_N] = {1'b1, NODE_W_DEF'(n + ARENA_COLS)};
            if (c > 0) t[n[NODE_W_DEF-1:0]][HEAD_E] = {1'b1, NODE_W_DEF'(n - 1)};
            if (n >= ARENA_COLS) t[n[NODE_W_DEF-1:0]][HEAD_S] = {1'b1, NODE_W_DEF'(n - ARENA_COLS)};
            if (c < ARENA_COLS - 1) t[n[NODE_W_DEF-1:0]][HEAD_W] = {1'b1, NODE_W_DEF'(n + 1)};
        end
        return t;
    endfunction

    localparam adj_t ADJ = build_adj();
endpackage

// File: rtl/node_dir_rom.sv
// node_dir_rom: combinational lookup of the absolute heading from src to dst over the arena table.
module node_dir_rom
    import nav_pkg::*;
#(
    parameter int NODE_W = NODE_W_DEF
) (
    input  logic [NODE_W-1:0] src,
    input  logic [NODE_W-1:0] dst,
    output logic              valid,
    output logic [1:0]        heading
);
    logic [NODE_W_DEF-1:0] fi;
    logic [NODE_W_DEF:0]   e;

    always_comb begin
        fi = NODE_W_DEF'(src);
        e = '0;
        valid = 1'b0;
        heading = 2'd0;
        for (int d = 0; d < 4; d++) begin
            e = ADJ[fi][d[1:0]];
            if (src == NODE_W'(fi) && e[NODE_W_DEF] && dst == NODE_W'(e[NODE_W_DEF-1:0])) begin
                valid = 1'b1;
                heading = d[1:0];
            end
        end
    end
endmodule

// File: rtl/path_navigator.sv
// path_navigator: turns a FIFO of visited node IDs into relative turn commands with a valid/ready handshake.
// Define NAV_UTURN_EN to allow U-turn commands; otherwise a U-turn step is an error.
module path_navigator
    import nav_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int NODE_W = NODE_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        node_wr,
    input  logic [NODE_W-1:0]           node_in,
    input  logic                        path_done,
    input  logic [NODE_W-1:0]           start_node,
    input  logic [1:0]                  init_heading,
    output logic                        dir_valid,
    input  logic                        dir_ready,
    output logic [1:0]                  dir_out,
    output logic [NODE_W-1:0]           dir_node,
    output logic                        nav_busy,
    output logic                        nav_done,
    output logic                        nav_err,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);

    state_e            state, state_n;
    logic [NODE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [NODE_W-1:0] prev_node, head_node;
    logic [1:0]        heading, rom_heading, turn;
    logic              rom_valid, turn_bad, full, pop, push, overflow, step, latch_start;

    node_dir_rom #(.NODE_W(NODE_W)) u_rom (
        .src(prev_node), .dst(head_node), .valid(rom_valid), .heading(rom_heading)
    );

    assign head_node = mem[rd_ptr];
    assign full      = fifo_level == (AW+1)'(FIFO_DEPTH);
    assign pop       = state == S_RUN && fifo_level != '0;
    assign push      = node_wr && state inside {S_IDLE, S_RUN, S_PRESENT} && (!full || pop);
    assign overflow  = node_wr && state inside {S_RUN, S_PRESENT} && full && !pop;
    assign turn      = rom_heading - heading;
`ifdef NAV_UTURN_EN
    assign turn_bad  = 1'b0;
`else
    assign turn_bad  = turn == TURN_UTURN;
`endif
    assign dir_valid = state == S_PRESENT;
    assign nav_busy  = state inside {S_RUN, S_PRESENT};
    assign nav_done  = state == S_DONE;
    assign nav_err   = state == S_ERR;

    always_comb begin
        state_n = state;
        step = 1'b0;
        latch_start = 1'b0;
        case (state)
            S_IDLE: if (node_wr || path_done) begin
                state_n = S_RUN;
                latch_start = 1'b1;
            end
            S_RUN: if (overflow) state_n = S_ERR;
            else if (pop) begin
                // Repeated node is a no-op step and is discarded in place.
                if (head_node != prev_node) begin
                    state_n = (!rom_valid || turn_bad) ? S_ERR : S_PRESENT;
                    step = rom_valid && !turn_bad;
                end
            end
            else if (path_done && !push) state_n = S_DONE;
            S_PRESENT: state_n = overflow ? S_ERR : dir_ready ? S_RUN : S_PRESENT;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            prev_node  <= '0;
            heading    <= '0;
            dir_out    <= '0;
            dir_node   <= '0;
        end else begin
            state      <= state_n;
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr + AW'(pop);
            fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
            if (latch_start) begin
                prev_node <= start_node;
                heading   <= init_heading;
            end
            if (step) begin
                prev_node <= head_node;
                heading   <= rom_heading;
                dir_out   <= turn;
                dir_node  <= head_node;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= node_in;
    end
endmodule

// File: tb/tb_path_navigator.sv
// tb_path_navigator: table-driven single-step vectors plus directed multi-cycle sequences for path_navigator.
module tb_path_navigator;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset, node_wr, path_done, dir_valid, dir_ready, nav_busy, nav_done, nav_err;
    logic [4:0] node_in, start_node, dir_node, fifo_level;
    logic [1:0] init_heading, dir_out;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    path_navigator #(.FIFO_DEPTH(DEPTH), .NODE_W(5)) dut (
        .clk(clk), .reset(reset), .node_wr(node_wr), .node_in(node_in), .path_done(path_done),
        .start_node(start_node), .init_heading(init_heading), .dir_valid(dir_valid),
        .dir_ready(dir_ready), .dir_out(dir_out), .dir_node(dir_node), .nav_busy(nav_busy),
        .nav_done(nav_done), .nav_err(nav_err), .fifo_level(fifo_level)
    );

    typedef struct {
        logic [4:0] start;
        logic [1:0] head;
        logic [4:0] node;
        logic       err;
        logic [1:0] dir;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [4:0] s, input logic [1:0] h);
        reset = 1'b1;
        node_wr = 1'b0;
        node_in = '0;
        path_done = 1'b0;
        dir_ready = 1'b0;
        start_node = s;
        init_heading = h;
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [4:0] n);
        node_wr = 1'b1;
        node_in = n;
        tick();
        node_wr = 1'b0;
    endtask

    initial begin
        int hs;
        logic [1:0] first_dir, last_dir;
        logic [4:0] last_node;
        logic [4:0] pn [3];

        vecs[0]  = '{5'd29, 2'd0, 5'd28, 1'b0, 2'd1};
        vecs[1]  = '{5'd29, 2'd1, 5'd28, 1'b0, 2'd0};
        vecs[2]  = '{5'd29, 2'd2, 5'd28, 1'b0, 2'd3};
        vecs[3]  = '{5'd29, 2'd3, 5'd28, 1'b1, 2'd0};
        vecs[4]  = '{5'd20, 2'd0, 5'd28, 1'b0, 2'd0};
        vecs[5]  = '{5'd20, 2'd1, 5'd12, 1'b0, 2'd1};
        vecs[6]  = '{5'd20, 2'd0, 5'd21, 1'b0, 2'd3};
        vecs[7]  = '{5'd29, 2'd0, 5'd5,  1'b1, 2'd0};
        vecs[8]  = '{5'd8,  2'd0, 5'd7,  1'b1, 2'd0};
        vecs[9]  = '{5'd31, 2'd2, 5'd23, 1'b0, 2'd0};
        vecs[10] = '{5'd7,  2'd0, 5'd8,  1'b1, 2'd0};

        do_reset(5'd29, 2'd0);
        chk("rst_valid", dir_valid, 0);
        chk("rst_dir", dir_out, 0);
        chk("rst_node", dir_node, 0);
        chk("rst_busy", nav_busy, 0);
        chk("rst_done", nav_done, 0);
        chk("rst_err", nav_err, 0);
        chk("rst_level", fifo_level, 0);

        for (int i = 0; i < 11; i++) begin
            do_reset(vecs[i].start, vecs[i].head);
            push(vecs[i].node);
            chk($sformatf("v%0d_early_valid", i), dir_valid, 0);
            tick();
            chk($sformatf("v%0d_valid", i), dir_valid, !vecs[i].err);
            chk($sformatf("v%0d_err", i), nav_err, vecs[i].err);
            if (!vecs[i].err) begin
                chk($sformatf("v%0d_dir", i), dir_out, vecs[i].dir);
                chk($sformatf("v%0d_node", i), dir_node, vecs[i].node);
            end
        end

        // Duplicate node discarded, then latency from RUN, then reverse step
        do_reset(5'd29, 2'd0);
        dir_ready = 1'b1;
        hs = 0;
        first_dir = 2'd3;
        last_dir = 2'd3;
        last_node = '0;
        for (int c = 0; c < 10; c++) begin
            if (dir_valid && dir_ready) begin
                if (hs == 0) first_dir = dir_out;
                hs++;
                last_dir = dir_out;
                last_node = dir_node;
            end
            node_wr = c < 3;
            node_in = c == 2 ? 5'd27 : 5'd28;
            tick();
        end
        node_wr = 1'b0;
        chk("dup_handshakes", hs, 2);
        chk("dup_first_dir", first_dir, 1);
        chk("dup_second_dir", last_dir, 0);
        chk("dup_second_node", last_node, 27);
        push(5'd26);
        chk("run_lat_early", dir_valid, 0);
        tick();
        chk("run_lat_valid", dir_valid, 1);
        chk("run_lat_node", dir_node, 26);
        tick();
        push(5'd27);
        tick();
        chk("reverse_err", nav_err, 1);
        chk("reverse_valid", dir_valid, 0);

        // Backpressure holds the command stable
        do_reset(5'd29, 2'd0);
        push(5'd28);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("hold%0d_valid", c), dir_valid, 1);
            chk($sformatf("hold%0d_dir", c), dir_out, 1);
            chk($sformatf("hold%0d_node", c), dir_node, 28);
            tick();
        end
        dir_ready = 1'b1;
        tick();
        dir_ready = 1'b0;
        chk("hold_release", dir_valid, 0);

        // Fill to full, then simultaneous push and pop while full
        do_reset(5'd29, 2'd0);
        push(5'd28);
        tick();
        for (int c = 0; c < DEPTH; c++) push(5'd28);
        chk("full_level", fifo_level, DEPTH);
        chk("full_err", nav_err, 0);
        dir_ready = 1'b1;
        tick();
        dir_ready = 1'b0;
        push(5'd28);
        chk("full_pushpop_level", fifo_level, DEPTH);
        chk("full_pushpop_err", nav_err, 0);

        // Overflow
        do_reset(5'd29, 2'd0);
        push(5'd28);
        tick();
        for (int c = 0; c < DEPTH + 1; c++) push(5'd28);
        chk("ovf_level", fifo_level, DEPTH);
        chk("ovf_err", nav_err, 1);
        chk("ovf_valid", dir_valid, 0);
        chk("ovf_busy", nav_busy, 0);

        // Three-node path then path_done
        do_reset(5'd29, 2'd0);
        dir_ready = 1'b1;
        pn[0] = 5'd28;
        pn[1] = 5'd27;
        pn[2] = 5'd19;
        hs = 0;
        last_dir = 2'd3;
        for (int c = 0; c < 14; c++) begin
            if (dir_valid && dir_ready) begin
                hs++;
                last_dir = dir_out;
            end
            node_wr = c < 3;
            if (c < 3) node_in = pn[c];
            path_done = c >= 3;
            tick();
        end
        node_wr = 1'b0;
        chk("path_handshakes", hs, 3);
        chk("path_last_dir", last_dir, 1);
        chk("path_done", nav_done, 1);
        chk("path_busy", nav_busy, 0);
        push(5'd20);
        chk("done_ignore_level", fifo_level, 0);
        chk("done_sticky", nav_done, 1);

        // path_done with a simultaneous push stays in RUN
        do_reset(5'd29, 2'd0);
        dir_ready = 1'b1;
        path_done = 1'b1;
        tick();
        push(5'd28);
        chk("pd_push_done", nav_done, 0);
        chk("pd_push_busy", nav_busy, 1);
        chk("pd_push_level", fifo_level, 1);
        tick();
        chk("pd_push_valid", dir_valid, 1);
        tick();
        tick();
        chk("pd_push_final_done", nav_done, 1);

        // Reset asserted while presenting a command
        do_reset(5'd29, 2'd0);
        push(5'd28);
        tick();
        chk("mid_present_valid", dir_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", dir_valid, 0);
        chk("mid_rst_dir", dir_out, 0);
        chk("mid_rst_node", dir_node, 0);
        chk("mid_rst_busy", nav_busy, 0);
        chk("mid_rst_done", nav_done, 0);
        chk("mid_rst_err", nav_err, 0);
        chk("mid_rst_level", fifo_level, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_valid", dir_valid, 0);
        chk("post_rst_busy", nav_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
